// File: rtl/rv_core_pkg.sv
// Shared core types and constants.
// Fetch FSM encoding and the fetch buffer entry layout live here.
package rv_core_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Instruction buffer: small synchronous FIFO of {pc, instr} entries.
// Flush empties it in one cycle; storage is zeroed only by reset.
module if_fifo
  import rv_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [XLEN-1:0]              pc_i,
  input  logic [ILEN-1:0]              instr_i,
  input  logic                         pop_i,
  output logic [XLEN-1:0]              pc_o,
  output logic [ILEN-1:0]              instr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= '{pc: pc_i, instr: instr_i};
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop_i) begin
        rd_q <= ptr_inc(rd_q);
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign pc_o    = mem_q[rd_q].pc;
  assign instr_o = mem_q[rd_q].instr;
  assign count_o = count_q;

  // The request credit rule must keep a slot free for every push.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (!rst_n)
    (push_i && !flush_i) |-> (count_q != CW'(DEPTH))
  );

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues credit-limited imem requests,
// buffers responses and drops stale ones after a redirect.
module instruction_fetch
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int UW = CW + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   count;
  logic [CW-1:0]   out_after;
  logic [UW-1:0]   credit_used;
  logic [XLEN-1:0] target;
  logic            rsp;
  logic            drop;
  logic            push;
  logic            pop;
  logic            req_fire;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};
  assign rsp    = imem_rsp_valid & (state_q != S_IDLE);
  assign out_after = outstanding_q - CW'(rsp);

  assign if_valid = (count != '0) & (state_q == S_RUN)
                  & ~redirect_valid;
  assign pop      = if_valid & if_ready;

  // Credits count both in-flight requests and occupied buffer slots.
  assign credit_used = UW'(outstanding_q) + UW'(count) - UW'(pop);
  assign imem_req_valid = (state_q == S_RUN) & ~redirect_valid
                        & (credit_used < UW'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign drop = rsp & (redirect_valid | (discard_q != '0));
  assign push = rsp & ~drop;

  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    outstanding_d = out_after + CW'(req_fire);
    if (redirect_valid) begin
      pc_d      = target;
      resp_pc_d = target;
      discard_d = out_after;
    end else begin
      if (req_fire) pc_d = pc_q + PC_INC;
      if (push) resp_pc_d = resp_pc_q + PC_INC;
      if (drop) discard_d = discard_q - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (redirect_valid && out_after != '0) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (redirect_valid) begin
          state_d = (out_after != '0) ? S_FLUSH : S_RUN;
        end else if (discard_d == '0) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  if_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pc_i    (resp_pc_q),
    .instr_i (imem_rsp_data),
    .pop_i   (pop),
    .pc_o    (if_pc),
    .instr_o (if_instr),
    .count_o (count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: in-order memory model with variable
// latency, queue-level fetch model, directed and random phases.
module tb_instruction_fetch;
  import rv_core_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC(RPC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_instr(if_instr),
    .if_pc(if_pc)
  );

  int tests = 0;
  int fails = 0;

  // stimulus controls, applied at the falling edge
  bit rst_cmd = 1'b0;
  bit rdy_cmd = 1'b1;
  bit rnd     = 1'b0;
  int lat     = 1;

  // memory model
  logic [31:0] mq_a[$];
  int          mq_d[$];
  int          last_due = 0;
  int          cyc = 0;

  // behavioural fetch model
  bit          m_started = 1'b0;
  logic [31:0] m_pc = RPC;
  logic [31:0] m_rpc = RPC;
  int          m_out = 0;
  int          m_disc = 0;
  logic [63:0] m_fq[$];

  // logs for directed checks
  logic [31:0] req_log[$];
  logic [31:0] del_log[$];
  int          rel = -1;
  int          first_req = -1;
  int          first_val = -1;
  logic [31:0] first_instr = '0;
  bit          last_if_valid = 1'b0;
  bit          in_rst = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] qat(
    input logic [31:0] q[$], input int i
  );
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act, input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_pc      = RPC;
    m_rpc     = RPC;
    m_out     = 0;
    m_disc    = 0;
    m_fq.delete();
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc);
    bit rsp, ev, er, pop, rf;
    int used, oa, due;
    logic [63:0] hd;
    @(negedge clk);
    rst_n = rst_cmd;
    if (rnd) begin
      if_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 4) != 0);
    end else begin
      if_ready       = rdy_cmd;
      imem_req_ready = 1'b1;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst_n) begin
      mq_a.delete();
      mq_d.delete();
      last_due = 0;
    end else if (mq_a.size() > 0 && mq_d[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(mq_a[0]);
      void'(mq_a.pop_front());
      void'(mq_d.pop_front());
    end
    redirect_valid = redir && rst_n;
    redirect_pc    = rpc;
    #1;
    if (!rst_n) begin
      if (in_rst) begin
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
      end
      rel = -1;
      first_req = -1;
      first_val = -1;
    end else begin
      rel++;
      rsp = imem_rsp_valid && m_started;
      ev  = m_started && m_disc == 0 && m_fq.size() > 0 && !redir;
      pop = ev && if_ready;
      used = m_out + m_fq.size() - (pop ? 1 : 0);
      er  = m_started && m_disc == 0 && !redir && used < DEPTH;
      rf  = er && imem_req_ready;
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, er});
      if (er) chk("req_addr", imem_req_addr, m_pc);
      chk("if_valid", {31'b0, if_valid}, {31'b0, ev});
      if (ev) begin
        hd = m_fq[0];
        chk("if_pc", if_pc, hd[63:32]);
        chk("if_instr", if_instr, hd[31:0]);
      end
      last_if_valid = if_valid;
      if (imem_req_valid && imem_req_ready) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq_a.push_back(imem_req_addr);
        mq_d.push_back(due);
        req_log.push_back(imem_req_addr);
        if (first_req < 0) first_req = rel;
      end
      if (if_valid && first_val < 0) begin
        first_val   = rel;
        first_instr = if_instr;
      end
      if (if_valid && if_ready) del_log.push_back(if_pc);
      oa = m_out - (rsp ? 1 : 0);
      if (redir) begin
        m_pc   = {rpc[31:2], 2'b00};
        m_rpc  = m_pc;
        m_fq.delete();
        m_disc = oa;
        m_out  = oa;
      end else begin
        if (pop) void'(m_fq.pop_front());
        if (rsp) begin
          if (m_disc > 0) m_disc--;
          else begin
            m_fq.push_back({m_rpc, imem_rsp_data});
            m_rpc = m_rpc + 4;
          end
        end
        if (rf) m_pc = m_pc + 4;
        m_out = oa + (rf ? 1 : 0);
      end
      m_started = 1'b1;
    end
    @(posedge clk);
    cyc++;
    in_rst = !rst_n;
    if (!rst_n) model_reset();
  endtask

  task automatic do_reset();
    rst_cmd = 1'b0;
    step(1'b0, '0);
    step(1'b0, '0);
    rst_cmd = 1'b1;
    req_log.delete();
    del_log.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic wait_out2(input string nm);
    int k;
    k = 0;
    while (m_out != 2 && k < 20) begin
      step(1'b0, '0);
      k++;
    end
    chk(nm, m_out, 32'd2);
  endtask

  task automatic check_start(input string p);
    rdy_cmd = 1'b1;
    lat = 1;
    run(12);
    chk({p, "_req0"}, qat(req_log, 0), 32'h100);
    chk({p, "_req1"}, qat(req_log, 1), 32'h104);
    chk({p, "_req2"}, qat(req_log, 2), 32'h108);
    chk({p, "_first_req"}, first_req, 32'd1);
    chk({p, "_first_val"}, first_val, 32'd3);
    chk({p, "_first_instr"}, first_instr, 32'h1257_6520);
    chk({p, "_del0"}, qat(del_log, 0), 32'h100);
    chk({p, "_del1"}, qat(del_log, 1), 32'h104);
    chk({p, "_del3"}, qat(del_log, 3), 32'h10C);
    chk({p, "_nreq"}, req_log.size(), 32'd11);
    chk({p, "_ndel"}, del_log.size(), 32'd9);
  endtask

  initial begin
    int bad, n;
    // 1: reset release and streaming
    do_reset();
    check_start("t1");

    // 2: decode stall
    do_reset();
    rdy_cmd = 1'b0;
    run(12);
    #1;
    chk("t2_nreq", req_log.size(), 32'd2);
    chk("t2_ndel", del_log.size(), 32'd0);
    chk("t2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t2_count", 32'(dut.u_fifo.count_o), 32'd2);
    chk("t2_head_pc", if_pc, 32'h100);
    rdy_cmd = 1'b1;
    run(10);
    bad = 0;
    for (int i = 0; i < del_log.size(); i++)
      if (del_log[i] !== 32'h100 + 32'(4 * i)) bad++;
    chk("t2_order", bad, 32'd0);
    chk("t2_ndel_after", del_log.size(), 32'd10);

    // 3: redirect with two requests in flight, slow memory
    do_reset();
    lat = 3;
    wait_out2("t3_wait");
    step(1'b1, 32'h2002);
    #1;
    chk("t3_state", 32'(dut.state_q), 32'(S_FLUSH));
    req_log.delete();
    del_log.delete();
    run(15);
    chk("t3_req0", qat(req_log, 0), 32'h2000);
    chk("t3_del0", qat(del_log, 0), 32'h2000);
    bad = 0;
    foreach (del_log[i]) if (del_log[i] < 32'h2000) bad++;
    chk("t3_stale", bad, 32'd0);

    // 4: redirect against a response and a pending pop
    do_reset();
    lat = 1;
    run(8);
    n = del_log.size();
    step(1'b1, 32'h3000);
    chk("t4_valid_redir", {31'b0, last_if_valid}, 32'd0);
    chk("t4_no_xfer", del_log.size(), n);
    step(1'b0, '0);
    chk("t4_valid_next", {31'b0, last_if_valid}, 32'd0);
    run(6);
    chk("t4_del_new", qat(del_log, n), 32'h3000);

    // 5: back-to-back redirects
    do_reset();
    lat = 3;
    wait_out2("t5_wait");
    step(1'b1, 32'h400);
    step(1'b1, 32'h800);
    req_log.delete();
    del_log.delete();
    run(20);
    chk("t5_req0", qat(req_log, 0), 32'h800);
    chk("t5_del0", qat(del_log, 0), 32'h800);
    bad = 0;
    foreach (del_log[i]) if (del_log[i] < 32'h800) bad++;
    chk("t5_stale", bad, 32'd0);

    // 6: reset with a full buffer
    do_reset();
    lat = 1;
    rdy_cmd = 1'b0;
    run(6);
    chk("t6_full", 32'(dut.u_fifo.count_o), 32'd2);
    rst_cmd = 1'b0;
    step(1'b0, '0);
    #1;
    chk("t6_pc", dut.pc_q, RPC);
    chk("t6_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t6_if_valid", {31'b0, if_valid}, 32'd0);
    step(1'b0, '0);
    rst_cmd = 1'b1;
    req_log.delete();
    del_log.delete();
    check_start("t6");

    // random phase
    rnd = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 499) == 0) begin
        rst_cmd = 1'b0;
        run(2);
        rst_cmd = 1'b1;
      end else if ($urandom_range(0, 29) == 0) begin
        step(1'b1, $urandom);
      end else begin
        step(1'b0, '0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
